median_window_buf: RTL and testbench
====================================

# median_window_buf

Parametrised sliding-window buffer feeding the 1D median sorter. It accepts a framed sample stream over a valid/ready handshake and keeps the last WIN samples as parallel taps. It emits one centred window per input sample, padding the frame edges with zeros or replicated edge samples. It replaces the single-bit registers as the front end of the median datapath.

## Interface
- WIDTH, 8: sample width in bits.
- WIN, 5: window length; odd and ≥3. HALF = (WIN-1)/2.
- PAD_MODE, 0: edge padding. 0 = zero pad, 1 = replicate the first/last sample of the frame.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block can accept; combinational, equals (state != DRAIN).
- in_data  in  WIDTH  input sample.
- in_last  in  1  qualifies the final sample of a frame; sampled only on accept.
- win_data  out  WIN*WIDTH  taps; tap i is at [i*WIDTH +: WIDTH]; tap 0 is newest.
- win_center  out  WIDTH  equals tap HALF.
- win_valid  out  1  one-cycle pulse; win_data is a complete centred window.
- win_last  out  1  qualifies win_valid for the window centred on the frame's last sample.

## Operation
- Accept: in_valid && in_ready.
- Shift: taps move one place older (tap i → tap i+1), and tap 0 takes the new value.
- Per-tap shadow bits shift alongside the taps:
  - real: tap holds a frame sample, not a pad.
  - lastmark: tap holds the frame's last sample.
- win_valid, registered on each shift, equals real[HALF] after the shift. win_last equals lastmark[HALF] after the shift. Both are 0 on non-shift cycles.
- State IDLE (reset state):
  - On accept, tap 0 = in_data and taps 1..WIN-1 = pad. The pad is 0 (PAD_MODE 0) or in_data (PAD_MODE 1).
  - real = 1 at tap 0 only. lastmark[0] = in_last.
  - Next state is DRAIN if in_last, else RUN.
- State RUN:
  - On accept, shift in in_data with real = 1 and lastmark = in_last.
  - If in_last, capture the drain pad (0, or in_data for PAD_MODE 1) and go to DRAIN.
  - With no accept, hold all state.
- State DRAIN:
  - in_ready = 0. Each cycle, shift in the drain pad with real = 0.
  - The drain counter loads HALF-1 on entry and decrements each cycle. At 0, go to IDLE.
  - DRAIN always lasts exactly HALF cycles.
- Each frame of N samples yields exactly N win_valid pulses. Only the last pulse has win_last = 1.
- Taps are retained in IDLE. No pad or real bits from a previous frame leak into the next frame.

## Timing
- Reset values:
  - taps = 0; real, lastmark and drain pad = 0.
  - state = IDLE, so in_ready = 1.
  - win_valid = 0, win_last = 0.
- Latency: sample k's window has win_valid high in the cycle after the edge that accepted sample k+HALF. For the final HALF samples, the edge is the corresponding DRAIN shift instead.
- Throughput: one sample per cycle in RUN. After each frame there are HALF bubble cycles with in_ready low.
- in_valid during DRAIN is not accepted; the source must hold it. A sample presented in the final DRAIN cycle is accepted the following cycle, in IDLE.
- rst overrides everything, including mid-DRAIN. The next cycle is IDLE with all reset values, and no further win_valid for the aborted frame.
- There is no output backpressure; the consumer must take every win_valid pulse.

## Structure
- Shared package median_pkg holds:
  - PAD_ZERO = 0 and PAD_REPL = 1.
  - The state enum IDLE/RUN/DRAIN.
  - The window-flattening index helper.
- Sub-module window_shift_reg (params WIDTH, DEPTH) holds the tap array plus the real/lastmark bits. It has a "load with pad" port and a "shift" port; the FSM, drain counter and pad register live in median_window_buf.

## Test plan
- Reset: hold rst 3 cycles → win_valid=0, win_last=0, in_ready=1, win_data=0.
- Zero-pad, WIN=5, back-to-back frame 10,20,30,40,50 (in_last on 50):
  - First win_valid comes after the 3rd accept, with taps 0..4 = 30,20,10,0,0 and win_center=10.
  - Exactly 5 pulses in total; the last has taps 0,0,50,40,30 and win_last=1.
  - in_ready is low for exactly 2 cycles.
- PAD_MODE=1, WIN=5, single sample 7 with in_last:
  - Two DRAIN cycles, then exactly one window of all 7s with win_last=1.
- Gapped input: same frame with in_valid toggling every other cycle → identical window sequence, with pulses only on accept/drain cycles.
- in_valid held high through DRAIN with the next frame 1,2,3 queued:
  - Nothing is accepted while in_ready=0.
  - The first window of the new frame is 3,2,1,0,0 (zero mode), with no samples from the previous frame.
- rst asserted in the first DRAIN cycle → next cycle IDLE, in_ready=1, win_valid stays 0, taps=0.

Source files
------------

// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared types and helpers for the median datapath front end
package median_pkg;

  localparam int PAD_ZERO = 0;
  localparam int PAD_REPL = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // LSB position of tap idx inside a flattened window vector
  function automatic int tap_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/window_shift_reg.sv
// rtl/window_shift_reg.sv - tap array with per-tap real/lastmark shadow bits
module window_shift_reg
  import median_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_data,
  input  logic [WIDTH-1:0]       load_pad,
  input  logic                   load_last,
  input  logic                   shift,
  input  logic [WIDTH-1:0]       shift_data,
  input  logic                   shift_real,
  input  logic                   shift_last,
  output logic [DEPTH*WIDTH-1:0] taps,
  output logic [DEPTH-1:0]       real_bits,
  output logic [DEPTH-1:0]       last_bits
);

  // Load restarts the window for a new frame so nothing from the old frame survives
  always_ff @(posedge clk) begin
    if (rst) begin
      taps      <= '0;
      real_bits <= '0;
      last_bits <= '0;
    end else if (load) begin
      for (int i = 0; i < DEPTH; i++) begin
        taps[tap_lsb(i, WIDTH) +: WIDTH] <= (i == 0) ? load_data : load_pad;
      end
      real_bits <= DEPTH'(1);
      last_bits <= {{(DEPTH-1){1'b0}}, load_last};
    end else if (shift) begin
      taps      <= {taps[(DEPTH-1)*WIDTH-1:0], shift_data};
      real_bits <= {real_bits[DEPTH-2:0], shift_real};
      last_bits <= {last_bits[DEPTH-2:0], shift_last};
    end
  end

endmodule

// File: rtl/median_window_buf.sv
// rtl/median_window_buf.sv - framed sliding-window buffer emitting one centred window per sample
module median_window_buf
  import median_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int WIN      = 5,
  parameter int PAD_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic [WIN*WIDTH-1:0] win_data,
  output logic [WIDTH-1:0]     win_center,
  output logic                 win_valid,
  output logic                 win_last
);

  localparam int HALF = (WIN - 1) / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  state_t           state;
  logic [CW-1:0]    drain_cnt;
  logic [WIDTH-1:0] drain_pad;
  logic             shifted;

  logic             accept;
  logic             load;
  logic             shift;
  logic [WIDTH-1:0] pad_val;
  logic [WIDTH-1:0] shift_data;
  logic             shift_real;
  logic             shift_last;
  logic [WIN-1:0]   real_bits;
  logic [WIN-1:0]   last_bits;
  logic             unused_flags;

  assign in_ready   = (state != DRAIN);
  assign accept     = in_valid && in_ready;
  assign pad_val    = (PAD_MODE == PAD_REPL) ? in_data : '0;
  assign load       = accept && (state == IDLE);
  assign shift      = (accept && (state == RUN)) || (state == DRAIN);
  assign shift_data = (state == DRAIN) ? drain_pad : in_data;
  assign shift_real = (state != DRAIN);
  assign shift_last = (state != DRAIN) && in_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      drain_pad <= '0;
      shifted   <= 1'b0;
    end else begin
      shifted <= shift;
      case (state)
        IDLE, RUN: begin
          if (accept) begin
            if (in_last) begin
              state     <= DRAIN;
              drain_cnt <= CW'(HALF - 1);
              drain_pad <= pad_val;
            end else begin
              state <= RUN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= IDLE;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  window_shift_reg #(
    .WIDTH(WIDTH),
    .DEPTH(WIN)
  ) u_taps (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (in_data),
    .load_pad  (pad_val),
    .load_last (in_last),
    .shift     (shift),
    .shift_data(shift_data),
    .shift_real(shift_real),
    .shift_last(shift_last),
    .taps      (win_data),
    .real_bits (real_bits),
    .last_bits (last_bits)
  );

  // Pulses only in the cycle right after a shift; the centre flags then describe the new window
  assign win_valid    = shifted && real_bits[HALF];
  assign win_last     = shifted && last_bits[HALF];
  assign win_center   = win_data[tap_lsb(HALF, WIDTH) +: WIDTH];
  assign unused_flags = ^{real_bits, last_bits};

endmodule

// File: tb/tb_median_window_buf.sv
// tb/tb_median_window_buf.sv - randomized scoreboard bench for median_window_buf (zero and replicate pad)
module tb_median_window_buf;

  localparam int WIDTH = 8;
  localparam int WIN   = 5;
  localparam int HALF  = (WIN - 1) / 2;
  localparam int EW    = 1 + WIDTH + WIN * WIDTH;

  typedef logic [EW-1:0] ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic in_last = 1'b0;

  logic in_ready0, in_ready1;
  logic [WIN*WIDTH-1:0] win_data0, win_data1;
  logic [WIDTH-1:0] win_center0, win_center1;
  logic win_valid0, win_valid1, win_last0, win_last1;

  int errors = 0;
  int checks = 0;
  int low_obs = 0;
  int low_exp = 0;
  bit prev_shift = 1'b0;

  ent_t obs0[$], obs1[$], exp0[$], exp1[$];

  always #5 clk = ~clk;

  median_window_buf #(.WIDTH(WIDTH), .WIN(WIN), .PAD_MODE(0)) u_zero (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .in_last(in_last), .win_data(win_data0), .win_center(win_center0),
    .win_valid(win_valid0), .win_last(win_last0)
  );

  median_window_buf #(.WIDTH(WIDTH), .WIN(WIN), .PAD_MODE(1)) u_repl (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .in_last(in_last), .win_data(win_data1), .win_center(win_center1),
    .win_valid(win_valid1), .win_last(win_last1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // A window may only appear after an edge that accepted a sample or drained
  always @(posedge clk) prev_shift = !rst && ((in_valid && in_ready0) || !in_ready0);

  always @(negedge clk) begin
    if (in_ready0 === 1'b0) low_obs++;
    if (win_valid0) begin
      check("pulse_on_shift0", 64'(prev_shift), 64'd1);
      obs0.push_back({win_last0, win_center0, win_data0});
    end
    if (win_valid1) begin
      check("pulse_on_shift1", 64'(prev_shift), 64'd1);
      obs1.push_back({win_last1, win_center1, win_data1});
    end
  end

  // Window k of a frame holds samples k+HALF down to k-HALF, out-of-frame slots padded
  task automatic model_push(input int s[$]);
    int n;
    int idx;
    int v;
    logic [WIN*WIDTH-1:0] w;
    n = s.size();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < n; k++) begin
        w = '0;
        for (int i = 0; i < WIN; i++) begin
          idx = k + HALF - i;
          if (idx < 0)       v = (m == 1) ? s[0] : 0;
          else if (idx >= n) v = (m == 1) ? s[n-1] : 0;
          else               v = s[idx];
          w[i*WIDTH +: WIDTH] = v[WIDTH-1:0];
        end
        if (m == 0) exp0.push_back({k == n - 1, s[k][WIDTH-1:0], w});
        else        exp1.push_back({k == n - 1, s[k][WIDTH-1:0], w});
      end
    end
  endtask

  // gap_mode: 0 back-to-back, 1 idle cycle before every sample, 2 random idles
  task automatic send_frame(input int s[$], input int gap_mode);
    bit acc;
    int n;
    model_push(s);
    low_exp += HALF;
    for (int j = 0; j < s.size(); j++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = s[j][WIDTH-1:0];
      in_last  = (j == s.size() - 1);
      n = 0;
      do begin
        acc = in_ready0;
        @(negedge clk);
        n++;
      end while (!acc && n < 30);
      check("accept_timeout", 64'(acc), 64'd1);
      check("latency0", 64'(win_valid0), 64'(j >= HALF));
      check("latency1", 64'(win_valid1), 64'(j >= HALF));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic flush();
    int n;
    int k;
    n = 0;
    while (in_ready0 !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(n < 30), 64'd1);
    repeat (2) @(negedge clk);
    #1;
    check("count_zero", 64'(obs0.size()), 64'(exp0.size()));
    check("count_repl", 64'(obs1.size()), 64'(exp1.size()));
    k = (obs0.size() < exp0.size()) ? obs0.size() : exp0.size();
    for (int i = 0; i < k; i++) check($sformatf("win_zero[%0d]", i), 64'(obs0[i]), 64'(exp0[i]));
    k = (obs1.size() < exp1.size()) ? obs1.size() : exp1.size();
    for (int i = 0; i < k; i++) check($sformatf("win_repl[%0d]", i), 64'(obs1[i]), 64'(exp1[i]));
    check("ready_low_cycles", 64'(low_obs), 64'(low_exp));
    obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
    low_obs = 0;
    low_exp = 0;
  endtask

  initial begin
    int s[$];
    int len;
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s[$];
    int s2[$];
    int len;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_win_valid", 64'({win_valid0, win_valid1}), 64'd0);
    check("rst_win_last", 64'({win_last0, win_last1}), 64'd0);
    check("rst_in_ready", 64'({in_ready0, in_ready1}), 64'b11);
    check("rst_win_data0", 64'(win_data0), 64'd0);
    check("rst_win_data1", 64'(win_data1), 64'd0);
    rst = 1'b0;
    low_obs = 0;
    @(negedge clk);

    s = '{10, 20, 30, 40, 50};
    send_frame(s, 0);
    flush();

    s = '{7};
    send_frame(s, 0);
    flush();

    s = '{10, 20, 30, 40, 50};
    send_frame(s, 1);
    flush();

    // next frame presented while the previous one drains
    s  = '{5, 6, 7, 8};
    s2 = '{1, 2, 3};
    send_frame(s, 0);
    send_frame(s2, 0);
    flush();

    // reset in the first drain cycle drops the two remaining windows
    s = '{1, 2, 3, 4, 5};
    send_frame(s, 0);
    void'(exp0.pop_back()); void'(exp0.pop_back());
    void'(exp1.pop_back()); void'(exp1.pop_back());
    low_exp = low_exp - HALF + 1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready0), 64'd1);
    check("abort_win_valid", 64'({win_valid0, win_valid1}), 64'd0);
    check("abort_taps0", 64'(win_data0), 64'd0);
    check("abort_taps1", 64'(win_data1), 64'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_quiet", 64'({win_valid0, win_valid1}), 64'd0);
    end
    flush();

    for (int f = 0; f < 20; f++) begin
      s.delete();
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) s.push_back(int'($urandom_range(0, 255)));
      send_frame(s, int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) flush();
    end
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
